pulse_burst_gen: RTL

- Transmit side of the "trigger then N non-consecutive pulses under a qualifying window" protocol.
- On a rising edge of trig, the block raises window and emits exactly NUM_PULSES single-cycle pulses separated by at least one idle cycle. It then drops window and reports done.
- Sits ahead of blocks and SVA checkers that require window throughout pulse[=NUM_PULSES] after a trigger.

---
 rtl/pulse_burst_pkg.sv | 5 +
 rtl/pulse_burst_gen_rise_detect.sv | 11 +
 rtl/pulse_burst_gen.sv | 83 ++++++++
 3 files changed

// File: rtl/pulse_burst_pkg.sv
// pulse_burst_pkg: shared types and constants for the burst generator
package pulse_burst_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, PULSE, GAP, TAIL} state_t;
  localparam int MIN_GAP = 1;
endpackage

// File: rtl/pulse_burst_gen_rise_detect.sv
// rise_detect: trig history register, resets high so a held trig is not an edge
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic start
);
  logic trig_q;
  always_ff @(posedge clk) trig_q <= !rst_n ? 1'b1 : trig;
  assign start = trig & ~trig_q;
endmodule

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: trigger-started burst of NUM_PULSES spaced pulses under a window
module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int NUM_PULSES = 3,
  parameter int GAP_W      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            trig,
  input  logic [GAP_W-1:0]                gap_cfg,
  input  logic                            abort,
  output logic                            window,
  output logic                            pulse,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic [$clog2(NUM_PULSES+1)-1:0] pulse_cnt
);
  localparam int CW = $clog2(NUM_PULSES + 1);
  state_t           state;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_cnt;
  logic             start;
  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (trig),
    .start (start)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      window    <= 1'b0;
      pulse     <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      pulse_cnt <= '0;
      gap       <= GAP_W'(MIN_GAP);
      gap_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      pulse   <= 1'b0;
      if (state != IDLE && abort) begin
        state   <= IDLE;
        window  <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            state     <= LEAD;
            window    <= 1'b1;
            pulse_cnt <= '0;
            gap       <= gap_cfg < GAP_W'(MIN_GAP) ? GAP_W'(MIN_GAP) : gap_cfg;
          end
          LEAD: begin
            state     <= PULSE;
            pulse     <= 1'b1;
            pulse_cnt <= pulse_cnt + 1'b1;
          end
          PULSE: if (pulse_cnt == CW'(NUM_PULSES)) state <= TAIL;
          else begin
            state   <= GAP;
            gap_cnt <= gap;
          end
          GAP: if (gap_cnt <= GAP_W'(MIN_GAP)) begin
            state     <= PULSE;
            pulse     <= 1'b1;
            pulse_cnt <= pulse_cnt + 1'b1;
          end else gap_cnt <= gap_cnt - 1'b1;
          TAIL: begin
            state  <= IDLE;
            window <= 1'b0;
            done   <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
